ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, byte address of the first fetch after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, number of fetch-queue entries (fixed at 2; other values are unsupported).
REQ-003 SHALL size all data and PC ports with the `WIDTH macro from params.v (32).
REQ-004 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port imem_add, output, `WIDTH-2, word address to instruction memory, equal to pc[`WIDTH-1:2].
REQ-007 SHALL have port imem_data, input, `WIDTH, instruction returned combinationally in the same cycle for imem_add.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, `WIDTH, target byte address of the redirect.
REQ-010 SHALL have port inst_valid, output, 1, head queue entry is valid.
REQ-011 SHALL have port inst_ready, input, 1, decode accepts the head entry.
REQ-012 SHALL have port inst, output, `WIDTH, head-entry instruction.
REQ-013 SHALL have port inst_pc, output, `WIDTH, head-entry byte PC.
REQ-014 SHALL have port misalign_err, output, 1, sticky misaligned-redirect flag.

Function
REQ-015 SHALL implement states BOOT, FETCH and HALT; BOOT->FETCH after exactly one cycle, FETCH->HALT only per REQ-029, HALT exits only on reset.
REQ-016 SHALL not push in BOOT or HALT; imem_add is still driven from pc.
REQ-017 SHALL, in FETCH with no redirect, push {pc, imem_data} and advance pc by 4 when count<2 or a pop occurs in the same cycle; otherwise it holds pc and does not push.
REQ-018 SHALL wrap pc modulo 2^`WIDTH (0xFFFFFFFC+4 -> 0x00000000).
REQ-019 SHALL pop the head entry when inst_valid and inst_ready are both 1.
REQ-020 SHALL drive inst_valid=1 exactly when count!=0; inst and inst_pc are the head entry and hold stable while inst_valid=1 and inst_ready=0.
REQ-021 SHALL accept simultaneous push and pop at count=2 (count unchanged) and at count=1 (count unchanged, order preserved).
REQ-022 SHALL ignore inst_ready while count=0 (no underflow).
REQ-023 SHALL give redirect_valid priority over push and pop: in that cycle count<=0, pc<=redirect_pc, and no push occurs.
REQ-024 SHALL have redirect latency as follows: redirect in cycle N -> imem_add = target word in N+1 -> inst_valid=1 with inst_pc=target in N+2 (decode ready).
REQ-025 SHALL accept a redirect in BOOT (pc updated, state->FETCH) and ignore a redirect in HALT.
REQ-026 SHALL treat back-to-back redirects as last-wins; each one flushes.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set pc=RESET_PC, count=0, queue pointers 0, state=BOOT and misalign_err=0; outputs are then inst_valid=0, inst=0, inst_pc=0 and imem_add=RESET_PC[`WIDTH-1:2].
REQ-028 SHALL let reset asserted mid-operation override redirect, push and pop in that cycle and discard all queue contents.

Configuration
REQ-029 SHALL, with macro IFETCH_MISALIGN_EN defined, treat a redirect with redirect_pc[1:0]!=0 as follows: set misalign_err=1 (sticky), flush the queue, leave pc unchanged and enter HALT.
REQ-030 SHALL, without IFETCH_MISALIGN_EN, use redirect_pc with bits [1:0] forced to 0 and tie misalign_err to 0.

Verification
REQ-031 SHALL cover: reset with RESET_PC=0x100, inst_ready=1 -> imem_add=0x40 in BOOT; inst_pc 0x100, 0x104, 0x108 on consecutive cycles starting 2 cycles after reset release.
REQ-032 SHALL cover: inst_ready=0 for 5 cycles -> count saturates at 2, pc holds at head+8, inst/inst_pc stable; ready=1 -> in-order drain with no gap.
REQ-033 SHALL cover: redirect to 0x200 while count=2 -> inst_valid=0 next cycle; inst_pc=0x200 two cycles after the redirect; old entries never appear.
REQ-034 SHALL cover: pc=0xFFFFFFF8, free-running -> inst_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-035 SHALL cover: redirect to 0x202 -> with IFETCH_MISALIGN_EN, misalign_err=1, inst_valid=0 and no further pushes until reset; without the macro, fetch resumes at 0x200.
REQ-036 SHALL cover: rst=1 asserted with count=2 and redirect_valid=1 in the same cycle -> next cycle count=0, pc=RESET_PC, state=BOOT.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit feeding decode through a 2-entry fetch queue.
// Define IFETCH_MISALIGN_EN to halt on misaligned redirects instead of truncating them.
`ifndef WIDTH
`define WIDTH 32
`endif

module ifetch #(
    parameter logic [`WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned       FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [`WIDTH-3:0] imem_add,
    input  logic [`WIDTH-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [`WIDTH-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [`WIDTH-1:0] inst,
    output logic [`WIDTH-1:0] inst_pc,
    output logic              misalign_err
);

    localparam int unsigned PtrW   = $clog2(FQ_DEPTH);
    localparam int unsigned CountW = $clog2(FQ_DEPTH) + 1;

    typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

    state_e              state_q, state_d;
    logic [`WIDTH-1:0]   pc_q, pc_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [`WIDTH-1:0]   pc_mem_q [FQ_DEPTH];
    logic [`WIDTH-1:0]   pc_mem_d [FQ_DEPTH];
    logic [`WIDTH-1:0]   inst_mem_q [FQ_DEPTH];
    logic [`WIDTH-1:0]   inst_mem_d [FQ_DEPTH];
    logic                push;
    logic                pop;
`ifdef IFETCH_MISALIGN_EN
    logic                misalign_q, misalign_d;
`endif

    assign imem_add   = pc_q[`WIDTH-1:2];
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    // Gate head outputs so stale or post-reset storage never leaks out.
    assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        push       = 1'b0;
`ifdef IFETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif
        if (state_q != StHalt && redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef IFETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = StHalt;
            end else begin
                pc_d    = redirect_pc;
                state_d = StFetch;
            end
`else
            pc_d    = redirect_pc & ~`WIDTH'(3);
            state_d = StFetch;
`endif
        end else begin
            // A same-cycle pop frees a slot, so a full queue can still accept.
            push = (state_q == StFetch) && ((count_q < CountW'(FQ_DEPTH)) || pop);
            if (state_q == StBoot) begin
                state_d = StFetch;
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]   = pc_q;
                inst_mem_d[wr_ptr_q] = imem_data;
                wr_ptr_d             = wr_ptr_q + 1'b1;
                pc_d                 = pc_q + `WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CountW'(push) - CountW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef IFETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef IFETCH_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

`ifdef IFETCH_MISALIGN_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
